// File: rtl/rob_commit.sv
// In-order reorder buffer with single-entry commit per cycle.
// Normal entries retire to the register-file port; a faulting entry writes the exception CSRs and flushes.
module rob_commit #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             alloc_valid_i,
  input  logic [4:0]       alloc_dest_i,
  input  logic [31:0]      alloc_pc_i,
  output logic             alloc_ready_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             complete_valid_i,
  input  logic [TAG_W-1:0] complete_tag_i,
  input  logic [31:0]      complete_data_i,
  input  logic             complete_exc_i,
  input  logic [31:0]      complete_mcause_i,
  input  logic [31:0]      complete_mtval_i,
  output logic             write_enable_o,
  output logic [4:0]       write_addr_o,
  output logic [31:0]      write_data_o,
  output logic             write_exc_en_o,
  output logic [31:0]      write_data_mepc_o,
  output logic [31:0]      write_data_mcause_o,
  output logic [31:0]      write_data_mtval_o,
  output logic             flush_o,
  output logic             empty_o
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  localparam logic [TAG_W:0] COUNT_MAX = (TAG_W+1)'(DEPTH);

  state_t           r_state;
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             r_valid  [DEPTH];
  logic             r_done   [DEPTH];
  logic             r_exc    [DEPTH];
  logic [4:0]       r_dest   [DEPTH];
  logic [31:0]      r_pc     [DEPTH];
  logic [31:0]      r_data   [DEPTH];
  logic [31:0]      r_mcause [DEPTH];
  logic [31:0]      r_mtval  [DEPTH];

  logic w_commit;
  logic w_commit_exc;
  logic w_commit_norm;
  logic w_alloc_take;
  logic w_cmp_take;

  // Ready ignores a same-cycle commit, so a full ROB stalls one extra cycle.
  assign alloc_ready_o = rsn_i && (r_state == S_RUN) && (r_count < COUNT_MAX);
  assign alloc_tag_o   = r_tail;
  assign empty_o       = (r_count == '0);

  assign w_commit      = (r_state == S_RUN) && r_valid[r_head] && r_done[r_head];
  assign w_commit_exc  = w_commit && r_exc[r_head];
  assign w_commit_norm = w_commit && !r_exc[r_head];
  assign w_alloc_take  = alloc_valid_i && alloc_ready_o && !w_commit_exc;
  assign w_cmp_take    = complete_valid_i && (r_state == S_RUN) && r_valid[complete_tag_i];

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state             <= S_RUN;
      r_head              <= '0;
      r_tail              <= '0;
      r_count             <= '0;
      write_enable_o      <= 1'b0;
      write_addr_o        <= '0;
      write_data_o        <= '0;
      write_exc_en_o      <= 1'b0;
      write_data_mepc_o   <= '0;
      write_data_mcause_o <= '0;
      write_data_mtval_o  <= '0;
      flush_o             <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_done[i]   <= 1'b0;
        r_exc[i]    <= 1'b0;
        r_dest[i]   <= '0;
        r_pc[i]     <= '0;
        r_data[i]   <= '0;
        r_mcause[i] <= '0;
        r_mtval[i]  <= '0;
      end
    end else begin
      write_enable_o <= 1'b0;
      write_exc_en_o <= 1'b0;
      flush_o        <= 1'b0;

      if (r_state == S_FLUSH)
        r_state <= S_RUN;

      if (w_cmp_take) begin
        r_done[complete_tag_i]   <= 1'b1;
        r_exc[complete_tag_i]    <= complete_exc_i;
        r_data[complete_tag_i]   <= complete_data_i;
        r_mcause[complete_tag_i] <= complete_mcause_i;
        r_mtval[complete_tag_i]  <= complete_mtval_i;
      end

      if (w_alloc_take) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_exc[r_tail]   <= 1'b0;
        r_dest[r_tail]  <= alloc_dest_i;
        r_pc[r_tail]    <= alloc_pc_i;
        r_tail          <= r_tail + 1'b1;
      end

      // Placed after completion so retiring the head wins over a late completion to it.
      if (w_commit_norm) begin
        write_enable_o  <= (r_dest[r_head] != 5'd0);
        write_addr_o    <= r_dest[r_head];
        write_data_o    <= r_data[r_head];
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + 1'b1;
      end

      if (w_commit_exc) begin
        write_exc_en_o      <= 1'b1;
        flush_o             <= 1'b1;
        write_data_mepc_o   <= r_pc[r_head];
        write_data_mcause_o <= r_mcause[r_head];
        write_data_mtval_o  <= r_mtval[r_head];
        for (int i = 0; i < DEPTH; i++) begin
          r_valid[i] <= 1'b0;
          r_done[i]  <= 1'b0;
        end
        r_head  <= '0;
        r_tail  <= '0;
        r_state <= S_FLUSH;
      end

      if (w_commit_exc)
        r_count <= '0;
      else if (w_alloc_take && !w_commit_norm)
        r_count <= r_count + 1'b1;
      else if (!w_alloc_take && w_commit_norm)
        r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: in-order commit, full stall, exception flush, dest 0, async reset.
module tb_rob_commit;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        alloc_valid_i;
  logic [4:0]  alloc_dest_i;
  logic [31:0] alloc_pc_i;
  logic        alloc_ready_o;
  logic [2:0]  alloc_tag_o;
  logic        complete_valid_i;
  logic [2:0]  complete_tag_i;
  logic [31:0] complete_data_i;
  logic        complete_exc_i;
  logic [31:0] complete_mcause_i;
  logic [31:0] complete_mtval_i;
  logic        write_enable_o;
  logic [4:0]  write_addr_o;
  logic [31:0] write_data_o;
  logic        write_exc_en_o;
  logic [31:0] write_data_mepc_o;
  logic [31:0] write_data_mcause_o;
  logic [31:0] write_data_mtval_o;
  logic        flush_o;
  logic        empty_o;

  int n_tests = 0;
  int n_fail  = 0;

  rob_commit #(.DEPTH(8), .TAG_W(3)) dut (
    .clk_i              (clk_i),
    .rsn_i              (rsn_i),
    .alloc_valid_i      (alloc_valid_i),
    .alloc_dest_i       (alloc_dest_i),
    .alloc_pc_i         (alloc_pc_i),
    .alloc_ready_o      (alloc_ready_o),
    .alloc_tag_o        (alloc_tag_o),
    .complete_valid_i   (complete_valid_i),
    .complete_tag_i     (complete_tag_i),
    .complete_data_i    (complete_data_i),
    .complete_exc_i     (complete_exc_i),
    .complete_mcause_i  (complete_mcause_i),
    .complete_mtval_i   (complete_mtval_i),
    .write_enable_o     (write_enable_o),
    .write_addr_o       (write_addr_o),
    .write_data_o       (write_data_o),
    .write_exc_en_o     (write_exc_en_o),
    .write_data_mepc_o  (write_data_mepc_o),
    .write_data_mcause_o(write_data_mcause_o),
    .write_data_mtval_o (write_data_mtval_o),
    .flush_o            (flush_o),
    .empty_o            (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rsn_i = 1'b0;
    step();
    rsn_i = 1'b1;
    step();
  endtask

  task automatic alloc(input logic [4:0] dest, input logic [31:0] pc, input logic [2:0] exp_tag);
    alloc_valid_i = 1'b1;
    alloc_dest_i  = dest;
    alloc_pc_i    = pc;
    check("alloc_tag", 32'(alloc_tag_o), 32'(exp_tag));
    step();
    alloc_valid_i = 1'b0;
  endtask

  task automatic complete(input logic [2:0] tag, input logic [31:0] data, input logic exc,
                          input logic [31:0] mcause, input logic [31:0] mtval);
    complete_valid_i  = 1'b1;
    complete_tag_i    = tag;
    complete_data_i   = data;
    complete_exc_i    = exc;
    complete_mcause_i = mcause;
    complete_mtval_i  = mtval;
    step();
    complete_valid_i  = 1'b0;
    complete_exc_i    = 1'b0;
  endtask

  initial begin
    rsn_i = 1'b0;
    alloc_valid_i = 1'b0; alloc_dest_i = '0; alloc_pc_i = '0;
    complete_valid_i = 1'b0; complete_tag_i = '0; complete_data_i = '0;
    complete_exc_i = 1'b0; complete_mcause_i = '0; complete_mtval_i = '0;
    #12;

    // Reset state
    check("rst_ready", 32'(alloc_ready_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_we", 32'(write_enable_o), 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);
    rsn_i = 1'b1;
    step();
    check("post_rst_ready", 32'(alloc_ready_o), 32'd1);

    // Single commit
    alloc(5'd5, 32'h100, 3'd0);
    check("t1_empty", 32'(empty_o), 32'd0);
    complete(3'd0, 32'hDEAD, 1'b0, 32'h0, 32'h0);
    check("t1_we_early", 32'(write_enable_o), 32'd0);
    step();
    check("t1_we", 32'(write_enable_o), 32'd1);
    check("t1_addr", 32'(write_addr_o), 32'd5);
    check("t1_data", write_data_o, 32'hDEAD);
    check("t1_empty_after", 32'(empty_o), 32'd1);
    step();
    check("t1_we_drop", 32'(write_enable_o), 32'd0);

    // Out-of-order completion, in-order commit (head=tail=1 here)
    alloc(5'd1, 32'h110, 3'd1);
    alloc(5'd2, 32'h114, 3'd2);
    alloc(5'd3, 32'h118, 3'd3);
    complete(3'd3, 32'h33, 1'b0, 32'h0, 32'h0);
    check("t2_we_a", 32'(write_enable_o), 32'd0);
    complete(3'd1, 32'h11, 1'b0, 32'h0, 32'h0);
    check("t2_we_b", 32'(write_enable_o), 32'd0);
    complete(3'd2, 32'h22, 1'b0, 32'h0, 32'h0);
    check("t2_c0_we", 32'(write_enable_o), 32'd1);
    check("t2_c0_addr", 32'(write_addr_o), 32'd1);
    check("t2_c0_data", write_data_o, 32'h11);
    step();
    check("t2_c1_we", 32'(write_enable_o), 32'd1);
    check("t2_c1_addr", 32'(write_addr_o), 32'd2);
    check("t2_c1_data", write_data_o, 32'h22);
    step();
    check("t2_c2_we", 32'(write_enable_o), 32'd1);
    check("t2_c2_addr", 32'(write_addr_o), 32'd3);
    check("t2_c2_data", write_data_o, 32'h33);
    step();
    check("t2_we_drop", 32'(write_enable_o), 32'd0);
    check("t2_empty", 32'(empty_o), 32'd1);

    // Full ROB: ready stays low during the commit cycle, allocation lands the cycle after
    do_reset();
    for (int i = 0; i < 8; i++)
      alloc(5'(10 + i), 32'h200 + 32'(4 * i), 3'(i));
    check("t3_full_ready", 32'(alloc_ready_o), 32'd0);
    check("t3_full_tag", 32'(alloc_tag_o), 32'd0);
    alloc_valid_i = 1'b1;
    alloc_dest_i  = 5'd20;
    alloc_pc_i    = 32'h300;
    complete(3'd0, 32'h44, 1'b0, 32'h0, 32'h0);
    check("t3_ready_k", 32'(alloc_ready_o), 32'd0);
    step();
    check("t3_commit_we", 32'(write_enable_o), 32'd1);
    check("t3_commit_data", write_data_o, 32'h44);
    check("t3_ready_k1", 32'(alloc_ready_o), 32'd1);
    check("t3_tag_wrap", 32'(alloc_tag_o), 32'd0);
    step();
    alloc_valid_i = 1'b0;
    check("t3_refull_ready", 32'(alloc_ready_o), 32'd0);
    check("t3_tail_next", 32'(alloc_tag_o), 32'd1);

    // Exception commit and flush; allocation held during the flush is dropped
    do_reset();
    alloc(5'd6, 32'h400, 3'd0);
    alloc(5'd7, 32'h404, 3'd1);
    alloc(5'd8, 32'h408, 3'd2);
    complete(3'd1, 32'h77, 1'b1, 32'h2, 32'h13);
    complete(3'd0, 32'hA0, 1'b0, 32'h0, 32'h0);
    check("t4_we_early", 32'(write_enable_o), 32'd0);
    alloc_valid_i = 1'b1;
    alloc_dest_i  = 5'd9;
    alloc_pc_i    = 32'h500;
    step();
    check("t4_c0_we", 32'(write_enable_o), 32'd1);
    check("t4_c0_addr", 32'(write_addr_o), 32'd6);
    check("t4_c0_data", write_data_o, 32'hA0);
    check("t4_c0_exc", 32'(write_exc_en_o), 32'd0);
    step();
    check("t4_exc_en", 32'(write_exc_en_o), 32'd1);
    check("t4_flush", 32'(flush_o), 32'd1);
    check("t4_exc_we", 32'(write_enable_o), 32'd0);
    check("t4_mepc", write_data_mepc_o, 32'h404);
    check("t4_mcause", write_data_mcause_o, 32'h2);
    check("t4_mtval", write_data_mtval_o, 32'h13);
    check("t4_empty", 32'(empty_o), 32'd1);
    check("t4_ready_flush", 32'(alloc_ready_o), 32'd0);
    step();
    check("t4_flush_drop", 32'(flush_o), 32'd0);
    check("t4_exc_drop", 32'(write_exc_en_o), 32'd0);
    check("t4_ready_back", 32'(alloc_ready_o), 32'd1);
    check("t4_empty_after", 32'(empty_o), 32'd1);
    check("t4_tag_after", 32'(alloc_tag_o), 32'd0);
    alloc_valid_i = 1'b0;
    complete(3'd2, 32'h88, 1'b0, 32'h0, 32'h0);
    step();
    check("t4_tag2_never", 32'(write_enable_o), 32'd0);

    // dest 0 retires without a register write
    alloc(5'd0, 32'h600, 3'd0);
    complete(3'd0, 32'h55, 1'b0, 32'h0, 32'h0);
    step();
    check("t5_no_we", 32'(write_enable_o), 32'd0);
    check("t5_empty", 32'(empty_o), 32'd1);
    check("t5_tail", 32'(alloc_tag_o), 32'd1);

    // Async reset mid-operation
    alloc(5'd11, 32'h700, 3'd1);
    alloc(5'd12, 32'h704, 3'd2);
    alloc(5'd13, 32'h708, 3'd3);
    alloc(5'd14, 32'h70C, 3'd4);
    complete(3'd2, 32'h99, 1'b0, 32'h0, 32'h0);
    complete(3'd1, 32'h98, 1'b0, 32'h0, 32'h0);
    step();
    check("t6_pre_we", 32'(write_enable_o), 32'd1);
    #2;
    rsn_i = 1'b0;
    #1;
    check("t6_rst_we", 32'(write_enable_o), 32'd0);
    check("t6_rst_empty", 32'(empty_o), 32'd1);
    check("t6_rst_ready", 32'(alloc_ready_o), 32'd0);
    step();
    rsn_i = 1'b1;
    step();
    check("t6_rel_we", 32'(write_enable_o), 32'd0);
    step();
    check("t6_rel_we2", 32'(write_enable_o), 32'd0);
    check("t6_rel_empty", 32'(empty_o), 32'd1);
    check("t6_rel_tag", 32'(alloc_tag_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order reorder buffer and commit stage. Sits directly upstream of the integer register file.
- Decode allocates entries in program order. Execute units complete entries by tag, out of order.
- Each cycle, the block retires at most one completed head entry by driving the register-file write port or the exception-CSR write port.
- A committed exception flushes every in-flight entry and pulses flush_o to the front end.

Parameters:
- DEPTH, 8: number of ROB entries; must be a power of two, minimum 2.
- TAG_W, 3: tag width; equals log2(DEPTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rsn_i  in  1  reset, asynchronous, active-low.
- alloc_valid_i  in  1  decode requests one entry.
- alloc_dest_i  in  5  destination register index; 0 means no register write.
- alloc_pc_i  in  32  PC of the instruction.
- alloc_ready_o  out  1  an entry can be accepted this cycle.
- alloc_tag_o  out  TAG_W  tag assigned to the current request (equals the tail pointer).
- complete_valid_i  in  1  an execute unit reports a result.
- complete_tag_i  in  TAG_W  entry being completed.
- complete_data_i  in  32  result value.
- complete_exc_i  in  1  the instruction raised an exception.
- complete_mcause_i  in  32  cause value.
- complete_mtval_i  in  32  bad address or instruction.
- write_enable_o  out  1  register-file write strobe.
- write_addr_o  out  5  register-file write index.
- write_data_o  out  32  register-file write data.
- write_exc_en_o  out  1  exception-CSR write strobe.
- write_data_mepc_o  out  32  PC of the faulting entry.
- write_data_mcause_o  out  32  cause of the faulting entry.
- write_data_mtval_o  out  32  tval of the faulting entry.
- flush_o  out  1  one-cycle pipeline flush pulse.
- empty_o  out  1  ROB holds no entries.

Behaviour:
- Reset (async, rsn_i low):
  - head, tail and count = 0; every entry's valid and done bits = 0; state = RUN.
  - All registered outputs = 0; empty_o = 1; alloc_ready_o = 0 while rsn_i is low.
- Entry fields: valid, done, exc, dest[4:0], pc, data, mcause, mtval.
- Allocation:
  - Handshake fires when alloc_valid_i && alloc_ready_o.
  - On fire: entry[tail] is loaded with valid=1, done=0, exc=0 plus dest and pc; tail increments; pointers wrap modulo DEPTH.
  - alloc_ready_o = (state==RUN) && (count < DEPTH). It is combinational and does not look ahead to a same-cycle commit, so a full ROB refuses allocation even when the head retires that cycle.
- Completion:
  - If complete_valid_i and entry[tag].valid, the edge sets done=1 and stores data, exc, mcause and mtval.
  - Completion to an invalid entry is ignored.
  - In state FLUSH, completion is ignored.
- Commit:
  - Condition: state==RUN && entry[head].valid && entry[head].done, evaluated from the registered entry state.
  - Minimum latency: completion at edge k; commit outputs are driven from edge k+1 and are visible for one cycle.
  - Non-exception commit: write_enable_o = (dest != 0); write_addr_o = dest; write_data_o = data. The entry is cleared, head increments, count decrements.
  - Exception commit: write_exc_en_o = 1 and flush_o = 1 for one cycle, with mepc = pc, mcause and mtval from the entry; write_enable_o = 0. At that edge every valid bit is cleared, head = tail = count = 0, and state moves to FLUSH.
  - The exception-CSR write port is expected to apply the cause-dependent mepc adjustment itself.
- Strobes: all strobe outputs drop to 0 on the cycle following their pulse unless a new commit occurs.
- State machine:
  - RUN -> FLUSH on an exception commit.
  - FLUSH -> RUN unconditionally after 1 cycle.
  - In FLUSH, alloc_ready_o = 0 and alloc_valid_i is dropped.
- Simultaneous events:
  - Allocation and normal commit in the same cycle: count is unchanged.
  - Allocation in the same cycle as an exception commit: the allocation is discarded (the flush wins).
  - Completion of the head entry in the same cycle it is evaluated: no effect that cycle (not yet done); it commits next cycle.
- empty_o = (count == 0). count is TAG_W+1 bits wide.

Test Plan:
- Reset then allocate dest=5, pc=0x100; complete tag 0 with data=0xDEAD -> write_enable_o=1, write_addr_o=5, write_data_o=0xDEAD one cycle after completion; empty_o=1 afterwards.
- Allocate tags 0,1,2; complete in order 2,0,1 -> commits strictly in order 0,1,2 on consecutive cycles, each write pulse one cycle wide.
- Allocate DEPTH entries -> alloc_ready_o=0 with count=8. Complete head and hold alloc_valid_i -> allocation accepted only on the cycle after the commit; tail wraps to 0.
- Allocate 3 entries; complete tag 1 with exc=1, mcause=0x2, mtval=0x13; complete tag 0 normally -> tag 0 writes, then write_exc_en_o=1, mepc=pc1, flush_o=1; tag 2 is never written; empty_o=1; alloc_ready_o=0 for one cycle.
- Entry with dest=0 completes -> no write_enable_o, head still advances.
- Assert rsn_i low mid-operation with 4 entries pending -> outputs 0 immediately, empty_o=1, no commit after release.
